// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select type and default sizing for the 1:4 buffered demux
package demux_pkg;
  localparam int NUM_CH    = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 2;
  typedef logic [1:0] chan_sel_t;
endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: per-channel registered FIFO with no fall-through and no pass-through when full
module demux_chan_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign head   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  // storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= push_data;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/demux4_16_bits_buf.sv
// demux4_16_bits_buf: steers one valid/ready word stream into four independently stalling channel FIFOs
module demux4_16_bits_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  chan_sel_t         in_select,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready
);
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [WIDTH-1:0]  w_head [NUM_CH];
  // one-hot select decode, ready mux and per-channel push/pop enables
  always_comb begin
    w_sel    = NUM_CH'(1) << in_select;
    in_ready = !w_full[in_select];
    w_push   = (in_valid && in_ready) ? w_sel : '0;
    w_pop    = out_ready & ~w_empty;
  end
  assign out_valid = ~w_empty;
  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (w_push[i]),
      .push_data(in_data),
      .pop      (w_pop[i]),
      .full     (w_full[i]),
      .empty    (w_empty[i]),
      .head     (w_head[i])
    );
  end
endmodule

// File: doc/demux4_16_bits_buf.md
# demux4_16_bits_buf

Buffered 1-to-4 demultiplexer for 16-bit words: the steering counterpart to the team's 4:1 16-bit source-select mux. It accepts one word per cycle on a valid/ready input port, routes it by a 2-bit select into one of four per-channel FIFOs, and presents each channel on its own valid/ready output port. Each channel stalls independently, so a slow consumer blocks only its own channel. It sits between a single producer (datapath result bus) and four independent destinations.

## Interface
- `WIDTH`, default 16: data word width.
- `DEPTH`, default 2: entries per channel FIFO; must be a power of 2 and ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `in_data` input, WIDTH: word to route.
- `in_select` input, 2 bits: destination channel, 0..3.
- `in_valid` input, 1 bit: producer offers `in_data`/`in_select`.
- `in_ready` output, 1 bit: the selected channel can accept a word this cycle.
- `out_data0`..`out_data3` output, WIDTH each: head entry of channel i FIFO.
- `out_valid` output, 4 bits: bit i set when channel i FIFO is non-empty.
- `out_ready` input, 4 bits: bit i set when consumer i takes the head this cycle.

## Operation
- Push: `in_valid && in_ready` pushes `in_data` into FIFO `in_select` at that FIFO's write pointer.
- `in_ready = !full[in_select]`; combinational from `in_select` and registered occupancy only. It never depends on `in_valid` or `out_ready`.
- Pop: `out_valid[i] && out_ready[i]` removes channel i head; `out_data_i` shows the next entry the following cycle.
- `out_valid[i] = (count_i != 0)`; `out_data_i = mem_i[rd_ptr_i]`. Both are registered-state driven, with no combinational path from the input port.
- Per-channel state: `rd_ptr` and `wr_ptr` are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- Simultaneous push and pop on the same non-full, non-empty channel: count unchanged, both pointers advance.
- Push to a full channel is impossible because `in_ready` is 0. There is no pass-through when a pop and push coincide on a full channel, so `in_ready` stays 0 that cycle.
- Push into an empty channel: no fall-through. Data is visible on `out_data_i` one cycle later.
- Pops on other channels in the same cycle as a push are independent.
- `in_valid` with `in_ready = 0`: nothing is stored. The producer holds `in_data`/`in_select` stable until accepted.
- `out_valid[i]` with `out_ready[i] = 0`: the head and `out_valid[i]` hold.
- Order within a channel is strict FIFO. There is no ordering guarantee across channels.

## Timing
- Reset values:
  - `out_valid = 4'b0000`
  - `out_data0..3 = 0` (storage cleared)
  - all pointers and counts 0
  - `in_ready = 1` for every select
- Reset asserted mid-operation discards all buffered words immediately, asynchronously.
- Latency: a word accepted at edge N is presented on `out_data_i` with `out_valid[i] = 1` after edge N.
- Throughput: 1 word/cycle into any channel that is not full. Each channel sustains 1 word/cycle when push and pop overlap.

## Structure
- Package `demux_pkg`:
  - `NUM_CH = 4`
  - `chan_sel_t` (logic [1:0])
  - default `WIDTH`/`DEPTH` localparams
- Sub-module `demux_chan_fifo` (params WIDTH, DEPTH):
  - ports: clk, reset, push, push_data, pop, full, empty, head
  - instantiated four times by a generate loop
- Top level contains only the select decode, `in_ready` mux, and push/pop enables.

## Test plan
- Reset, then push 0x1234 sel=2 with `out_ready = 0` -> next cycle `out_valid = 4'b0100`, `out_data2 = 0x1234`, other data 0.
- Push 0xAAAA, then 0xBBBB, to sel=1 with `out_ready[1] = 0`, DEPTH=2 -> `in_ready = 0` while sel=1 and `in_ready = 1` for sel=0; then pop twice -> 0xAAAA, then 0xBBBB.
- Fill channel 3, then assert `out_ready[3]` and `in_valid` sel=3 in the same cycle -> no push (`in_ready = 0`); one word drains, and the push is accepted the next cycle.
- Channel 0 at count 1 with push 0x0F0F and pop in the same cycle -> count stays 1, head becomes 0x0F0F.
- 8 pushes to sel=0 with `out_ready[0] = 1` continuously -> 8 words out in order at 1/cycle; pointers wrap without loss.
- Assert `reset` mid-stream with channels 1 and 2 holding data -> `out_valid` goes to 0 immediately, with no clock edge needed; after release, the next push appears on its own.
